// File: rtl/ifm_pingpong_ctrl.sv
// ifm_pingpong_ctrl: ping-pong controller for a two-bank input feature map buffer.
// The producer fills one bank while the consumer reads the other
// NUMBER_OF_PASSES times, once per filter group.
// Optional feature: define IFM_PP_STALL_CNT_EN to add the saturating stall_count
// output, which counts the cycles in which the producer is blocked.
module ifm_pingpong_ctrl #(
  parameter int unsigned NUMBER_OF_PASSES = 2,
  parameter int unsigned STALL_CNT_WIDTH  = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start_from_previous,
  output logic                                end_to_previous,
  output logic                                wr_bank_sel,
  output logic                                start_to_next,
  input  logic                                end_from_next,
  output logic                                rd_bank_sel,
  output logic [$clog2(NUMBER_OF_PASSES)-1:0] pass_index,
  output logic [1:0]                          bank_full,
`ifdef IFM_PP_STALL_CNT_EN
  output logic [STALL_CNT_WIDTH-1:0]          stall_count,
`endif
  output logic                                overflow_err
);

  localparam int unsigned PIW = $clog2(NUMBER_OF_PASSES);
  localparam logic [PIW-1:0] LAST_PASS = PIW'(NUMBER_OF_PASSES - 1);

  localparam logic [1:0] RD_IDLE  = 2'b00;
  localparam logic [1:0] RD_START = 2'b01;
  localparam logic [1:0] RD_BUSY  = 2'b10;

  logic [1:0]     state_q, state_d;
  logic [1:0]     bank_full_q, bank_full_d;
  logic           wr_bank_q, wr_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic [PIW-1:0] pass_q, pass_d;
  logic           ovf_q, ovf_d;

  logic           wr_ready;
  logic           accept;
  logic           release_bank;

  assign wr_ready     = ~bank_full_q[wr_bank_q];
  assign accept       = start_from_previous & wr_ready;
  assign release_bank = (state_q == RD_BUSY) & end_from_next & (pass_q == LAST_PASS);

  assign end_to_previous = wr_ready;
  assign wr_bank_sel     = wr_bank_q;
  assign rd_bank_sel     = rd_bank_q;
  assign pass_index      = pass_q;
  assign bank_full       = bank_full_q;
  assign start_to_next   = (state_q == RD_START);
  assign overflow_err    = ovf_q;

  // Next-state logic: write pointer, bank flags, read FSM and sticky error.
  // A release and an acceptance in the same cycle always touch different banks,
  // so both flag updates are applied independently.
  always_comb begin
    state_d     = state_q;
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    pass_d      = pass_q;
    ovf_d       = ovf_q;

    if (accept) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = ~wr_bank_q;
    end else if (start_from_previous) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      RD_IDLE: begin
        if (bank_full_q[rd_bank_q]) state_d = RD_START;
      end
      RD_START: begin
        state_d = RD_BUSY;
      end
      RD_BUSY: begin
        if (end_from_next) begin
          if (release_bank) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
            pass_d                 = '0;
            state_d                = RD_IDLE;
          end else begin
            pass_d  = pass_q + 1'b1;
            state_d = RD_START;
          end
        end
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase

    if (end_from_next && (state_q != RD_BUSY)) ovf_d = 1'b1;
  end

  // Registered state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RD_IDLE;
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      pass_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      pass_q      <= pass_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef IFM_PP_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

  assign stall_count = stall_q;

  // Count producer-blocked cycles, holding at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (!wr_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`endif

endmodule

// File: tb/tb_ifm_pingpong_ctrl.sv
// Directed bench for ifm_pingpong_ctrl with NUMBER_OF_PASSES=2.
// Each expected consumer start is queued as {rd_bank_sel, pass_index} when the
// stimulus that causes it is applied. A negedge monitor pops the queue whenever
// start_to_next is high.
module tb_ifm_pingpong_ctrl;

  localparam int unsigned NP  = 2;
  localparam int unsigned PIW = $clog2(NP);

  logic           clk = 1'b0;
  logic           reset;
  logic           start_from_previous;
  logic           end_to_previous;
  logic           wr_bank_sel;
  logic           start_to_next;
  logic           end_from_next;
  logic           rd_bank_sel;
  logic [PIW-1:0] pass_index;
  logic [1:0]     bank_full;
  logic           overflow_err;
`ifdef IFM_PP_STALL_CNT_EN
  logic [15:0]    stall_count;
`endif

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  logic [PIW:0] sb[$];

  ifm_pingpong_ctrl #(
    .NUMBER_OF_PASSES(NP),
    .STALL_CNT_WIDTH (16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start_from_previous(start_from_previous),
    .end_to_previous    (end_to_previous),
    .wr_bank_sel        (wr_bank_sel),
    .start_to_next      (start_to_next),
    .end_from_next      (end_from_next),
    .rd_bank_sel        (rd_bank_sel),
    .pass_index         (pass_index),
    .bank_full          (bank_full),
`ifdef IFM_PP_STALL_CNT_EN
    .stall_count        (stall_count),
`endif
    .overflow_err       (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every consumer start must match the oldest queued expectation.
  always @(negedge clk) begin
    if (start_to_next === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_start", 32'(start_to_next), 32'd0);
      end else begin
        logic [PIW:0] e;
        e = sb.pop_front();
        check("start_bank_pass", 32'({rd_bank_sel, pass_index}), 32'(e));
      end
    end
  end

  initial begin
    reset = 1'b1;
    start_from_previous = 1'b0;
    end_from_next = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_bank_full", 32'(bank_full), 32'd0);
    check("rst_wr_sel", 32'(wr_bank_sel), 32'd0);
    check("rst_rd_sel", 32'(rd_bank_sel), 32'd0);
    check("rst_pass", 32'(pass_index), 32'd0);
    check("rst_start", 32'(start_to_next), 32'd0);
    check("rst_ovf", 32'(overflow_err), 32'd0);
    check("rst_wr_ready", 32'(end_to_previous), 32'd1);
`ifdef IFM_PP_STALL_CNT_EN
    check("rst_stall", 32'(stall_count), 32'd0);
`endif

    // First fill of bank 0 and the two passes over it.
    start_from_previous = 1'b1;
    sb.push_back({1'b0, PIW'(0)});
    tick();
    start_from_previous = 1'b0;
    check("a_bank_full", 32'(bank_full), 32'b01);
    check("a_wr_sel", 32'(wr_bank_sel), 32'd1);
    check("a_start_lat1", 32'(start_to_next), 32'd0);
    check("a_wr_ready", 32'(end_to_previous), 32'd1);
    tick();
    check("a_start_lat2", 32'(start_to_next), 32'd1);
    check("a_pass0", 32'(pass_index), 32'd0);
    tick();
    check("a_start_one_cycle", 32'(start_to_next), 32'd0);
    repeat (7) tick();
    end_from_next = 1'b1;
    sb.push_back({1'b0, PIW'(1)});
    tick();
    end_from_next = 1'b0;
    check("a_start_pass1", 32'(start_to_next), 32'd1);
    check("a_pass1", 32'(pass_index), 32'd1);
    tick();
    end_from_next = 1'b1;
    tick();
    end_from_next = 1'b0;
    check("a_rel_bank_full", 32'(bank_full), 32'b00);
    check("a_rel_rd_sel", 32'(rd_bank_sel), 32'd1);
    check("a_rel_pass", 32'(pass_index), 32'd0);
    check("a_rel_start", 32'(start_to_next), 32'd0);
    check("a_rel_ovf", 32'(overflow_err), 32'd0);

    // Fill both banks, then a third write is rejected.
    start_from_previous = 1'b1;
    sb.push_back({1'b1, PIW'(0)});
    tick();
    check("b_bank_full_1", 32'(bank_full), 32'b10);
    tick();
    check("b_bank_full_2", 32'(bank_full), 32'b11);
    check("b_wr_ready", 32'(end_to_previous), 32'd0);
    tick();
    start_from_previous = 1'b0;
    check("b_ovf", 32'(overflow_err), 32'd1);
    check("b_flags_kept", 32'(bank_full), 32'b11);
    check("b_wr_sel_kept", 32'(wr_bank_sel), 32'd1);

    // Drain bank 1, reader moves back to bank 0.
    end_from_next = 1'b1;
    sb.push_back({1'b1, PIW'(1)});
    tick();
    end_from_next = 1'b0;
    tick();
    end_from_next = 1'b1;
    sb.push_back({1'b0, PIW'(0)});
    tick();
    end_from_next = 1'b0;
    check("d_bank_full", 32'(bank_full), 32'b01);
    check("d_rd_sel", 32'(rd_bank_sel), 32'd0);
    check("d_wr_ready", 32'(end_to_previous), 32'd1);
    tick();
    tick();
    end_from_next = 1'b1;
    sb.push_back({1'b0, PIW'(1)});
    tick();
    end_from_next = 1'b0;
    tick();

    // Release of bank 0 coincides with a write into bank 1.
    end_from_next = 1'b1;
    start_from_previous = 1'b1;
    sb.push_back({1'b1, PIW'(0)});
    tick();
    end_from_next = 1'b0;
    start_from_previous = 1'b0;
    check("c_bank_full", 32'(bank_full), 32'b10);
    check("c_wr_sel", 32'(wr_bank_sel), 32'd0);
    check("c_rd_sel", 32'(rd_bank_sel), 32'd1);
    check("c_pass", 32'(pass_index), 32'd0);
    check("c_start_idle", 32'(start_to_next), 32'd0);
    tick();
    check("c_restart", 32'(start_to_next), 32'd1);
    tick();

    // Reset while busy with both banks full.
    start_from_previous = 1'b1;
    tick();
    start_from_previous = 1'b0;
    check("r_bank_full_pre", 32'(bank_full), 32'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r_bank_full", 32'(bank_full), 32'd0);
    check("r_wr_sel", 32'(wr_bank_sel), 32'd0);
    check("r_rd_sel", 32'(rd_bank_sel), 32'd0);
    check("r_pass", 32'(pass_index), 32'd0);
    check("r_start", 32'(start_to_next), 32'd0);
    check("r_ovf", 32'(overflow_err), 32'd0);
    check("r_wr_ready", 32'(end_to_previous), 32'd1);
`ifdef IFM_PP_STALL_CNT_EN
    check("r_stall", 32'(stall_count), 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r_no_pulse", 32'(start_to_next), 32'd0);
    end

    // Stray end_from_next while idle.
    end_from_next = 1'b1;
    tick();
    end_from_next = 1'b0;
    check("e_ovf", 32'(overflow_err), 32'd1);
    check("e_bank_full", 32'(bank_full), 32'd0);
    check("e_rd_sel", 32'(rd_bank_sel), 32'd0);
    check("e_pass", 32'(pass_index), 32'd0);
    check("e_start", 32'(start_to_next), 32'd0);
    tick();
    tick();
    check("e_ovf_sticky", 32'(overflow_err), 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
